wshb_sdram_arbiter: RTL and testbench
=====================================

Name: wshb_sdram_arbiter

Overview:
Two-master, one-slave Wishbone arbiter that shares the SDRAM Wishbone bus (wshb_if_sdram, 32-bit data) between master M0 (video frame-fetch reader) and master M1 (pixel/pattern writer). It runs in the sys_clk domain, between the two masters and hw_support's SDRAM slave port. Arbitration is per Wishbone cycle (cyc) and is round-robin or fixed-priority. A watchdog aborts stalled transfers.

Parameters:
ADR_W, 32, address width
DAT_W, 32, data width (SEL_W = DAT_W/8)
PRIO_M0, 0, 1 = fixed priority to M0; 0 = round-robin
TIMEOUT, 1024, max sys_clk cycles with stb high and no ack/err/rty before abort (>=2)

Ports:
sys_clk  in  1  system clock, 100 MHz
sys_rst_n  in  1  asynchronous active-low reset
mX_cyc, mX_stb, mX_we  in  1 each  master X (X=0,1) cycle/strobe/write
mX_adr  in  ADR_W  master X address
mX_dat_ms  in  DAT_W  master X write data
mX_sel  in  SEL_W  master X byte select
mX_cti  in  3  master X cycle type
mX_bte  in  2  master X burst type
mX_ack, mX_err, mX_rty  out  1 each  responses to master X
mX_dat_sm  out  DAT_W  read data to master X
s_cyc, s_stb, s_we  out  1 each  to SDRAM slave
s_adr  out  ADR_W ; s_dat_ms  out  DAT_W ; s_sel  out  SEL_W ; s_cti  out  3 ; s_bte  out  2
s_ack, s_err, s_rty  in  1 each  slave responses
s_dat_sm  in  DAT_W  slave read data
gnt  out  2  one-hot current grant (bit0 = M0, bit1 = M1); 00 when idle

Behaviour:
- Reset (sys_rst_n=0, async): state IDLE, gnt=00, last=M1 (M0 wins first tie), watchdog=0. All s_* outputs 0, all mX_ack/err/rty 0.
- FSM states: IDLE, GNT0, GNT1, ABORT.
- IDLE: if exactly one mX_cyc=1, go to GNTX. If both: PRIO_M0=1 -> GNT0; otherwise grant the master that is not last. Grant is registered, so s_cyc rises 1 cycle after mX_cyc.
- GNTX: s_* = mX_* (combinational mux). mX_ack/err/rty = s_ack/err/rty. The non-granted master gets ack/err/rty=0. mX_dat_sm = s_dat_sm for both masters. s_cyc = mX_cyc & gnt[X], so when the master drops cyc the slave sees it the same cycle. On mX_cyc=0: last<=X and go to IDLE (1 dead cycle, no back-to-back grant).
- Grant is never pre-empted mid-cycle. Bursts (cti=010) stay atomic.
- Watchdog: counts while in GNTX with s_stb=1 and none of s_ack/s_err/s_rty. It clears on any response or stb=0. When it reaches TIMEOUT-1: go to ABORT.
- ABORT (1 cycle): s_cyc=s_stb=0, mX_err=1 to the granted master, last<=X, then IDLE. The master must drop cyc on err. If the master keeps cyc asserted, it re-arbitrates normally.
- Simultaneous response and timeout on the same cycle: the response wins and the watchdog clears.
- In IDLE/ABORT, s_adr/dat/sel/cti/bte/we = 0.
- Asserting reset mid-transfer returns to IDLE immediately. s_cyc drops asynchronously with reset.

Optional Feature:
WSHB_ARB_STATS_EN: when defined, adds outputs stat_m0_acks, stat_m1_acks (32 bits each, wrapping counters of acks delivered per master) and stat_aborts (16 bits, saturating). All are reset to 0. When undefined, these ports and their logic do not exist and the behaviour above is unchanged.

Decomposition:
- Package wshb_arb_pkg: typedef enum logic [1:0] arb_state_t {IDLE, GNT0, GNT1, ABORT}; localparam CTI_CLASSIC=3'b000, CTI_INCR=3'b010, CTI_EOB=3'b111.
- One sub-module, wshb_arb_watchdog: counter with TIMEOUT parameter, inputs en/clr, output expire.

Test Plan:
- Single master: M0 issues a read at adr 0x100, slave acks at cycle 3 -> s_cyc rises 1 cycle after m0_cyc; m0_ack=1 once; m1_ack stays 0; gnt=01 then 00.
- Tie, round-robin: both cyc rise together from reset -> M0 granted first. After M0 drops cyc, 1 idle cycle, then gnt=10.
- PRIO_M0=1: both request continuously, each doing 1-beat cycles -> M0 always wins; M1 is granted only while m0_cyc=0.
- Burst atomicity: M1 does an 8-beat incrementing write (cti 010 to 111) while M0 requests -> all 8 acks go to M1; M0 is granted only afterwards.
- Timeout: TIMEOUT=16, slave never acks -> at cycle 16 of stb the bench sees the ABORT cycle: m0_err=1 for 1 cycle, s_cyc=0, then IDLE. Under WSHB_ARB_STATS_EN, stat_aborts=1.
- Reset mid-burst: pull sys_rst_n low during beat 3 -> s_cyc and gnt go to 0 immediately. After release, the first tie is granted to M0.

Source files
------------

// File: rtl/wshb_arb_pkg.sv
// Shared types and constants for the two-master SDRAM Wishbone arbiter.
package wshb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT0  = 2'd1,
        GNT1  = 2'd2,
        ABORT = 2'd3
    } arb_state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

endpackage

// File: rtl/wshb_sdram_arbiter_if.sv
// One Wishbone B4 bus segment; master modport is the initiator's view, slave the target's.
interface wshb_sdram_arbiter_if #(
    parameter int unsigned ADR_W = 32,
    parameter int unsigned DAT_W = 32
) ();
    localparam int unsigned SEL_W = DAT_W / 8;

    logic             cyc;
    logic             stb;
    logic             we;
    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] dat_ms;
    logic [DAT_W-1:0] dat_sm;
    logic [SEL_W-1:0] sel;
    logic [2:0]       cti;
    logic [1:0]       bte;
    logic             ack;
    logic             err;
    logic             rty;

    modport master (
        output cyc, stb, we, adr, dat_ms, sel, cti, bte,
        input  ack, err, rty, dat_sm
    );

    modport slave (
        input  cyc, stb, we, adr, dat_ms, sel, cti, bte,
        output ack, err, rty, dat_sm
    );
endinterface

// File: rtl/wshb_arb_watchdog.sv
// Stall watchdog: counts enabled cycles, fires so the abort lands on the TIMEOUT-th stalled cycle.
module wshb_arb_watchdog #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic en,
    input  logic clr,
    output logic expire
);
    localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt_q;

    // Firing one count early lets the registered FSM enter ABORT on the limit cycle.
    assign expire = en && (cnt_q == CW'(TIMEOUT - 2));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q <= '0;
        end else if (clr || expire) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
endmodule

// File: rtl/wshb_sdram_arbiter.sv
// Two-master Wishbone arbiter for the SDRAM port, per-cycle round-robin or M0 priority.
// Optional WSHB_ARB_STATS_EN adds ack/abort statistics counters.
module wshb_sdram_arbiter
    import wshb_arb_pkg::*;
#(
    parameter int unsigned ADR_W   = 32,
    parameter int unsigned DAT_W   = 32,
    parameter int unsigned PRIO_M0 = 0,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    wshb_sdram_arbiter_if.slave  m0,
    wshb_sdram_arbiter_if.slave  m1,
    wshb_sdram_arbiter_if.master s,
    output logic [1:0]           gnt
`ifdef WSHB_ARB_STATS_EN
    ,
    output logic [31:0]          stat_m0_acks,
    output logic [31:0]          stat_m1_acks,
    output logic [15:0]          stat_aborts
`endif
);
    localparam int unsigned SEL_W = DAT_W / 8;

    arb_state_t       state_q, state_d;
    logic             last_q, last_d;          // 1 = M1 was served last
    logic             abort_m1_q, abort_m1_d;
    logic             wd_en, wd_expire;
    logic             cyc_mux, stb_mux, we_mux;
    logic [ADR_W-1:0] adr_mux;
    logic [DAT_W-1:0] dat_mux;
    logic [SEL_W-1:0] sel_mux;
    logic [2:0]       cti_mux;
    logic [1:0]       bte_mux;
    logic             m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty;

    assign wd_en = (state_q == GNT0 || state_q == GNT1) && stb_mux && !(s.ack || s.err || s.rty);

    wshb_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .en       (wd_en),
        .clr      (!wd_en),
        .expire   (wd_expire)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            abort_m1_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            abort_m1_q <= abort_m1_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        abort_m1_d = abort_m1_q;
        unique case (state_q)
            IDLE: begin
                if (m0.cyc && m1.cyc) begin
                    state_d = (PRIO_M0 != 0 || last_q) ? GNT0 : GNT1;
                end else if (m0.cyc) begin
                    state_d = GNT0;
                end else if (m1.cyc) begin
                    state_d = GNT1;
                end
            end
            GNT0: begin
                if (!m0.cyc || wd_expire) begin
                    state_d    = m0.cyc ? ABORT : IDLE;
                    last_d     = 1'b0;
                    abort_m1_d = 1'b0;
                end
            end
            GNT1: begin
                if (!m1.cyc || wd_expire) begin
                    state_d    = m1.cyc ? ABORT : IDLE;
                    last_d     = 1'b1;
                    abort_m1_d = 1'b1;
                end
            end
            ABORT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt     = 2'b00;
        cyc_mux = 1'b0;
        stb_mux = 1'b0;
        we_mux  = 1'b0;
        adr_mux = '0;
        dat_mux = '0;
        sel_mux = '0;
        cti_mux = '0;
        bte_mux = '0;
        m0_ack  = 1'b0;
        m0_err  = 1'b0;
        m0_rty  = 1'b0;
        m1_ack  = 1'b0;
        m1_err  = 1'b0;
        m1_rty  = 1'b0;
        unique case (state_q)
            GNT0: begin
                gnt     = 2'b01;
                cyc_mux = m0.cyc;
                stb_mux = m0.cyc && m0.stb;
                we_mux  = m0.we;
                adr_mux = m0.adr;
                dat_mux = m0.dat_ms;
                sel_mux = m0.sel;
                cti_mux = m0.cti;
                bte_mux = m0.bte;
                m0_ack  = s.ack;
                m0_err  = s.err;
                m0_rty  = s.rty;
            end
            GNT1: begin
                gnt     = 2'b10;
                cyc_mux = m1.cyc;
                stb_mux = m1.cyc && m1.stb;
                we_mux  = m1.we;
                adr_mux = m1.adr;
                dat_mux = m1.dat_ms;
                sel_mux = m1.sel;
                cti_mux = m1.cti;
                bte_mux = m1.bte;
                m1_ack  = s.ack;
                m1_err  = s.err;
                m1_rty  = s.rty;
            end
            ABORT: begin
                m0_err = !abort_m1_q;
                m1_err = abort_m1_q;
            end
            default: ;
        endcase
    end

    assign s.cyc     = cyc_mux;
    assign s.stb     = stb_mux;
    assign s.we      = we_mux;
    assign s.adr     = adr_mux;
    assign s.dat_ms  = dat_mux;
    assign s.sel     = sel_mux;
    assign s.cti     = cti_mux;
    assign s.bte     = bte_mux;
    assign m0.ack    = m0_ack;
    assign m0.err    = m0_err;
    assign m0.rty    = m0_rty;
    assign m0.dat_sm = s.dat_sm;
    assign m1.ack    = m1_ack;
    assign m1.err    = m1_err;
    assign m1.rty    = m1_rty;
    assign m1.dat_sm = s.dat_sm;

`ifdef WSHB_ARB_STATS_EN
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            stat_m0_acks <= '0;
            stat_m1_acks <= '0;
            stat_aborts  <= '0;
        end else begin
            if (m0_ack) stat_m0_acks <= stat_m0_acks + 32'd1;
            if (m1_ack) stat_m1_acks <= stat_m1_acks + 32'd1;
            if (state_q == ABORT && stat_aborts != 16'hFFFF) stat_aborts <= stat_aborts + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_wshb_sdram_arbiter.sv
// Directed bench for wshb_sdram_arbiter: round-robin/TIMEOUT=16 instance plus a PRIO_M0 instance.
module tb_wshb_sdram_arbiter;
    import wshb_arb_pkg::*;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n;
    logic [1:0] gnt, gnt_p;
    int         errors = 0;
    int         checks = 0;

    always #5 sys_clk = ~sys_clk;

    wshb_sdram_arbiter_if m0_bus ();
    wshb_sdram_arbiter_if m1_bus ();
    wshb_sdram_arbiter_if s_bus ();
    wshb_sdram_arbiter_if pm0_bus ();
    wshb_sdram_arbiter_if pm1_bus ();
    wshb_sdram_arbiter_if ps_bus ();

`ifdef WSHB_ARB_STATS_EN
    logic [31:0] st_m0, st_m1, pst_m0, pst_m1;
    logic [15:0] st_ab, pst_ab;
`endif

    wshb_sdram_arbiter #(.ADR_W(32), .DAT_W(32), .PRIO_M0(0), .TIMEOUT(16)) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .m0       (m0_bus),
        .m1       (m1_bus),
        .s        (s_bus),
        .gnt      (gnt)
`ifdef WSHB_ARB_STATS_EN
        ,
        .stat_m0_acks(st_m0),
        .stat_m1_acks(st_m1),
        .stat_aborts (st_ab)
`endif
    );

    wshb_sdram_arbiter #(.ADR_W(32), .DAT_W(32), .PRIO_M0(1), .TIMEOUT(16)) dut_p (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .m0       (pm0_bus),
        .m1       (pm1_bus),
        .s        (ps_bus),
        .gnt      (gnt_p)
`ifdef WSHB_ARB_STATS_EN
        ,
        .stat_m0_acks(pst_m0),
        .stat_m1_acks(pst_m1),
        .stat_aborts (pst_ab)
`endif
    );

    // Zero-wait slave for the priority instance.
    assign ps_bus.ack    = ps_bus.cyc & ps_bus.stb;
    assign ps_bus.err    = 1'b0;
    assign ps_bus.rty    = 1'b0;
    assign ps_bus.dat_sm = 32'h0;

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic smp();
        @(negedge sys_clk);
    endtask

    task automatic init();
        {m0_bus.cyc, m0_bus.stb, m0_bus.we} = 3'b000;
        {m1_bus.cyc, m1_bus.stb, m1_bus.we} = 3'b000;
        {pm0_bus.cyc, pm0_bus.stb, pm0_bus.we} = 3'b000;
        {pm1_bus.cyc, pm1_bus.stb, pm1_bus.we} = 3'b000;
        m0_bus.adr = '0;  m0_bus.dat_ms = '0;  m0_bus.sel = 4'hF;  m0_bus.cti = 3'b000;
        m0_bus.bte = '0;
        m1_bus.adr = '0;  m1_bus.dat_ms = '0;  m1_bus.sel = 4'hF;  m1_bus.cti = 3'b000;
        m1_bus.bte = '0;
        pm0_bus.adr = 32'h10; pm0_bus.dat_ms = '0; pm0_bus.sel = 4'hF; pm0_bus.cti = '0;
        pm0_bus.bte = '0;
        pm1_bus.adr = 32'h20; pm1_bus.dat_ms = '0; pm1_bus.sel = 4'hF; pm1_bus.cti = '0;
        pm1_bus.bte = '0;
        s_bus.ack = 1'b0; s_bus.err = 1'b0; s_bus.rty = 1'b0; s_bus.dat_sm = '0;
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        m0_bus.cyc = 1'b1; m0_bus.stb = 1'b1; m0_bus.adr = 32'h44;
        s_bus.ack = 1'b1;
        smp();
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL rst_gnt: got %b want 00", gnt); end
        checks++; if (s_bus.cyc !== 1'b0) begin errors++; $display("FAIL rst_scyc: got %b want 0", s_bus.cyc); end
        checks++; if (s_bus.stb !== 1'b0) begin errors++; $display("FAIL rst_sstb: got %b want 0", s_bus.stb); end
        checks++; if (s_bus.adr !== 32'h0) begin errors++; $display("FAIL rst_sadr: got %h want 0", s_bus.adr); end
        checks++; if (m0_bus.ack !== 1'b0) begin errors++; $display("FAIL rst_m0ack: got %b want 0", m0_bus.ack); end
        checks++; if (m0_bus.err !== 1'b0) begin errors++; $display("FAIL rst_m0err: got %b want 0", m0_bus.err); end
        step();
        m0_bus.cyc = 1'b0; m0_bus.stb = 1'b0; s_bus.ack = 1'b0;
        sys_rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        m0_bus.cyc = 1'b1; m0_bus.stb = 1'b1; m0_bus.we = 1'b0; m0_bus.adr = 32'h100;
        smp();
        checks++; if (s_bus.cyc !== 1'b0) begin errors++; $display("FAIL single_scyc_lat: got %b want 0", s_bus.cyc); end
        step();
        smp();
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL single_gnt: got %b want 01", gnt); end
        checks++; if (s_bus.cyc !== 1'b1) begin errors++; $display("FAIL single_scyc: got %b want 1", s_bus.cyc); end
        checks++; if (s_bus.adr !== 32'h100) begin errors++; $display("FAIL single_sadr: got %h want 100", s_bus.adr); end
        step();
        s_bus.ack = 1'b1; s_bus.dat_sm = 32'hCAFE_F00D;
        smp();
        checks++; if (m0_bus.ack !== 1'b1) begin errors++; $display("FAIL single_m0ack: got %b want 1", m0_bus.ack); end
        checks++; if (m1_bus.ack !== 1'b0) begin errors++; $display("FAIL single_m1ack: got %b want 0", m1_bus.ack); end
        checks++; if (m0_bus.dat_sm !== 32'hCAFE_F00D) begin errors++; $display("FAIL single_dat: got %h want cafef00d", m0_bus.dat_sm); end
        step();
        s_bus.ack = 1'b0; m0_bus.cyc = 1'b0; m0_bus.stb = 1'b0;
        smp();
        checks++; if (s_bus.cyc !== 1'b0) begin errors++; $display("FAIL single_drop: got %b want 0", s_bus.cyc); end
        step();
        smp();
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL single_idle: got %b want 00", gnt); end
        step();
    endtask

    task automatic test_tie_rr();
        sys_rst_n = 1'b0;
        step();
        sys_rst_n = 1'b1;
        m0_bus.cyc = 1'b1; m0_bus.stb = 1'b1; m0_bus.adr = 32'h10;
        m1_bus.cyc = 1'b1; m1_bus.stb = 1'b1; m1_bus.adr = 32'h20;
        smp();
        step();
        s_bus.ack = 1'b1;
        smp();
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL tie_first: got %b want 01", gnt); end
        checks++; if (m1_bus.ack !== 1'b0) begin errors++; $display("FAIL tie_m1ack: got %b want 0", m1_bus.ack); end
        step();
        s_bus.ack = 1'b0; m0_bus.cyc = 1'b0; m0_bus.stb = 1'b0;
        step();
        smp();
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL tie_dead: got %b want 00", gnt); end
        step();
        s_bus.ack = 1'b1;
        smp();
        checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL tie_second: got %b want 10", gnt); end
        checks++; if (s_bus.adr !== 32'h20) begin errors++; $display("FAIL tie_sadr: got %h want 20", s_bus.adr); end
        checks++; if (m1_bus.ack !== 1'b1) begin errors++; $display("FAIL tie_m1ack2: got %b want 1", m1_bus.ack); end
        step();
        s_bus.ack = 1'b0; m1_bus.cyc = 1'b0; m1_bus.stb = 1'b0;
        step();
        step();
    endtask

    task automatic test_prio();
        pm0_bus.cyc = 1'b1; pm0_bus.stb = 1'b1;
        pm1_bus.cyc = 1'b1; pm1_bus.stb = 1'b1;
        smp();
        step();
        smp();
        checks++; if (gnt_p !== 2'b01) begin errors++; $display("FAIL prio_first: got %b want 01", gnt_p); end
        checks++; if (pm1_bus.ack !== 1'b0) begin errors++; $display("FAIL prio_m1ack: got %b want 0", pm1_bus.ack); end
        step();
        pm0_bus.cyc = 1'b0; pm0_bus.stb = 1'b0;
        step();
        pm0_bus.cyc = 1'b1; pm0_bus.stb = 1'b1;
        step();
        smp();
        checks++; if (gnt_p !== 2'b01) begin errors++; $display("FAIL prio_again: got %b want 01", gnt_p); end
        step();
        pm0_bus.cyc = 1'b0; pm0_bus.stb = 1'b0;
        step();
        step();
        smp();
        checks++; if (gnt_p !== 2'b10) begin errors++; $display("FAIL prio_m1_gnt: got %b want 10", gnt_p); end
        checks++; if (pm1_bus.ack !== 1'b1) begin errors++; $display("FAIL prio_m1ack2: got %b want 1", pm1_bus.ack); end
        step();
        pm1_bus.cyc = 1'b0; pm1_bus.stb = 1'b0;
        step();
        step();
    endtask

    task automatic test_burst();
        int m1_acks = 0;
        int m0_bad  = 0;
        int gnt_bad = 0;
        m1_bus.cyc = 1'b1; m1_bus.stb = 1'b1; m1_bus.we = 1'b1; m1_bus.adr = 32'h200;
        m1_bus.dat_ms = 32'hD0; m1_bus.cti = CTI_INCR;
        step();
        m0_bus.cyc = 1'b1; m0_bus.stb = 1'b1; m0_bus.we = 1'b0; m0_bus.adr = 32'h300;
        s_bus.ack = 1'b1;
        for (int b = 0; b < 8; b++) begin
            if (b > 0) begin
                m1_bus.adr    = 32'h200 + 32'(4 * b);
                m1_bus.dat_ms = 32'hD0 + 32'(b);
                m1_bus.cti    = (b == 7) ? CTI_EOB : CTI_INCR;
            end
            smp();
            if (m1_bus.ack === 1'b1) m1_acks++;
            if (m0_bus.ack !== 1'b0) m0_bad++;
            if (gnt !== 2'b10) gnt_bad++;
            if (b == 7) begin
                checks++; if (s_bus.cti !== CTI_EOB) begin errors++; $display("FAIL burst_eob: got %b want 111", s_bus.cti); end
                checks++; if (s_bus.dat_ms !== 32'hD7) begin errors++; $display("FAIL burst_dat: got %h want d7", s_bus.dat_ms); end
                checks++; if (s_bus.adr !== 32'h21C) begin errors++; $display("FAIL burst_adr: got %h want 21c", s_bus.adr); end
            end
            step();
        end
        m1_bus.cyc = 1'b0; m1_bus.stb = 1'b0; m1_bus.we = 1'b0; m1_bus.cti = CTI_CLASSIC;
        s_bus.ack = 1'b0;
        checks++; if (m1_acks != 8) begin errors++; $display("FAIL burst_m1acks: got %0d want 8", m1_acks); end
        checks++; if (m0_bad != 0) begin errors++; $display("FAIL burst_m0ack: got %0d want 0", m0_bad); end
        checks++; if (gnt_bad != 0) begin errors++; $display("FAIL burst_gnt: got %0d want 0", gnt_bad); end
        smp();
        checks++; if (s_bus.cyc !== 1'b0) begin errors++; $display("FAIL burst_end_scyc: got %b want 0", s_bus.cyc); end
        step();
        smp();
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL burst_dead: got %b want 00", gnt); end
        step();
        smp();
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL burst_m0_after: got %b want 01", gnt); end
        checks++; if (s_bus.adr !== 32'h300) begin errors++; $display("FAIL burst_m0_adr: got %h want 300", s_bus.adr); end
        step();
        s_bus.ack = 1'b1;
        step();
        s_bus.ack = 1'b0; m0_bus.cyc = 1'b0; m0_bus.stb = 1'b0;
        step();
        step();
    endtask

    task automatic test_timeout();
        int bad = 0;
        m0_bus.cyc = 1'b1; m0_bus.stb = 1'b1; m0_bus.adr = 32'h400;
        step();
        for (int k = 1; k <= 15; k++) begin
            smp();
            if (gnt !== 2'b01 || s_bus.stb !== 1'b1 || m0_bus.err !== 1'b0) bad++;
            step();
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL to_stall: got %0d bad cycles want 0", bad); end
        smp();
        checks++; if (m0_bus.err !== 1'b1) begin errors++; $display("FAIL to_err: got %b want 1", m0_bus.err); end
        checks++; if (s_bus.cyc !== 1'b0) begin errors++; $display("FAIL to_scyc: got %b want 0", s_bus.cyc); end
        checks++; if (m1_bus.err !== 1'b0) begin errors++; $display("FAIL to_m1err: got %b want 0", m1_bus.err); end
        step();
        m0_bus.cyc = 1'b0; m0_bus.stb = 1'b0;
        smp();
        checks++; if (m0_bus.err !== 1'b0) begin errors++; $display("FAIL to_err_once: got %b want 0", m0_bus.err); end
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL to_idle: got %b want 00", gnt); end
`ifdef WSHB_ARB_STATS_EN
        checks++; if (st_ab !== 16'd1) begin errors++; $display("FAIL to_stat: got %0d want 1", st_ab); end
`endif
        step();
    endtask

    task automatic test_reset_mid_burst();
        m1_bus.cyc = 1'b1; m1_bus.stb = 1'b1; m1_bus.we = 1'b1; m1_bus.adr = 32'h500;
        m1_bus.cti = CTI_INCR;
        step();
        s_bus.ack = 1'b1;
        for (int b = 0; b < 3; b++) begin
            smp();
            step();
            m1_bus.adr = 32'h500 + 32'(4 * (b + 1));
        end
        #2;
        sys_rst_n = 1'b0;
        #1;
        checks++; if (s_bus.cyc !== 1'b0) begin errors++; $display("FAIL rstmid_scyc: got %b want 0", s_bus.cyc); end
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL rstmid_gnt: got %b want 00", gnt); end
        checks++; if (m1_bus.ack !== 1'b0) begin errors++; $display("FAIL rstmid_ack: got %b want 0", m1_bus.ack); end
        s_bus.ack = 1'b0;
        m1_bus.cyc = 1'b0; m1_bus.stb = 1'b0; m1_bus.cti = CTI_CLASSIC;
        step();
        step();
        sys_rst_n = 1'b1;
        m0_bus.cyc = 1'b1; m0_bus.stb = 1'b1; m0_bus.adr = 32'h600;
        m1_bus.cyc = 1'b1; m1_bus.stb = 1'b1; m1_bus.adr = 32'h700;
        step();
        smp();
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL rstmid_tie: got %b want 01", gnt); end
        checks++; if (s_bus.adr !== 32'h600) begin errors++; $display("FAIL rstmid_adr: got %h want 600", s_bus.adr); end
        step();
        m0_bus.cyc = 1'b0; m0_bus.stb = 1'b0; m1_bus.cyc = 1'b0; m1_bus.stb = 1'b0;
        step();
    endtask

    initial begin
        init();
        test_reset();
        test_single();
        test_tie_rr();
        test_prio();
        test_burst();
        test_timeout();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
